sdram_wave_reader: RTL and testbench

//  Consumer for the voice-path SDRAM FIFO read port. Requests one wave (WAVE_SIZE words) at a time
//  and collects the returned words into a two-bank ping-pong buffer. Plays samples out one per
//  i_sample_tick toward the audio DAC path. Reports underrun when the playback bank is not yet filled.

---
 rtl/sdram_wave_reader_if.sv | 27 ++
 rtl/sdram_wave_reader.sv | 160 ++++++++++++++++
 tb/tb_sdram_wave_reader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wave_reader_if.sv
// Read-port bundle between the wave reader and the voice-path SDRAM FIFO.
// master = reader side, slave = FIFO side.
interface sdram_wave_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  o_rd;
  logic                  o_cls_raddr;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  i_rd_ef;
  logic                  i_rd_done;

  modport master (
    output o_rd,
    output o_cls_raddr,
    input  i_rd_data,
    input  i_rd_ef,
    input  i_rd_done
  );

  modport slave (
    input  o_rd,
    input  o_cls_raddr,
    output i_rd_data,
    output i_rd_ef,
    output i_rd_done
  );
endinterface

// File: rtl/sdram_wave_reader.sv
// Fetches one wave at a time from the SDRAM FIFO into a ping-pong buffer
// and plays it out one sample per tick, flagging underrun and overflow.
module sdram_wave_reader #(
  parameter int WAVE_SIZE  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int PTR_WIDTH  = 5,
  parameter int CLS_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_restart,
  sdram_wave_reader_if.master   fifo,
  input  logic                  i_sample_tick,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_vld,
  output logic                  o_underrun,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int DEPTH = 2 ** (PTR_WIDTH + 1);
  localparam int CW    = $clog2(CLS_CYCLES + 1);

  typedef logic [PTR_WIDTH:0]   cnt_t;
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [CW-1:0]        cls_t;

  localparam cnt_t WAVE_CNT = cnt_t'(WAVE_SIZE);
  localparam ptr_t LAST_RD  = ptr_t'(WAVE_SIZE - 1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cls_t CLS_LAST = cls_t'(CLS_CYCLES - 1);
  localparam cls_t CLS_ONE  = cls_t'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_REQ,
    ST_COLLECT
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0] full;
  logic       fill_bank;
  logic       play_bank;
  cnt_t       wr_ptr;
  ptr_t       rd_ptr;
  cls_t       cls_cnt;
  logic       restart_pend;

  logic       in_fill;
  logic       wr_room;
  logic       wr_en;
  cnt_t       wr_cnt;
  logic       fill_done;
  logic       play_go;
  logic       play_last;
  logic [1:0] set_m;
  logic [1:0] clr_m;

  always_comb begin
    in_fill   = (state == ST_REQ) || (state == ST_COLLECT);
    wr_room   = (wr_ptr != WAVE_CNT);
    wr_en     = in_fill && fifo.i_rd_ef && wr_room;
    wr_cnt    = wr_ptr + cnt_t'(wr_en);
    // the word arriving with done counts toward completion
    fill_done = in_fill && fifo.i_rd_done && (wr_cnt == WAVE_CNT);
    play_go   = i_sample_tick && (state != ST_CLEAR) && full[play_bank];
    play_last = play_go && (rd_ptr == LAST_RD);
    set_m     = fill_done ? (2'b01 << fill_bank) : 2'b00;
    clr_m     = play_last ? (2'b01 << play_bank) : 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[{fill_bank, wr_ptr[PTR_WIDTH-1:0]}] <= fifo.i_rd_data;
  end

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      full             <= 2'b00;
      fill_bank        <= 1'b0;
      play_bank        <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      cls_cnt          <= '0;
      restart_pend     <= 1'b0;
      fifo.o_rd        <= 1'b0;
      fifo.o_cls_raddr <= 1'b0;
      o_sample         <= '0;
      o_sample_vld     <= 1'b0;
      o_underrun       <= 1'b0;
      o_overflow       <= 1'b0;
    end else begin
      o_sample_vld <= play_go;
      o_underrun   <= i_sample_tick && !play_go;
      if (play_go) begin
        o_sample <= mem[{play_bank, rd_ptr}];
        rd_ptr   <= play_last ? '0 : rd_ptr + PTR_ONE;
        if (play_last)
          play_bank <= ~play_bank;
      end
      full <= (full | set_m) & ~clr_m;
      if (i_restart && state != ST_IDLE)
        restart_pend <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (i_restart || restart_pend) begin
            state            <= ST_CLEAR;
            fifo.o_cls_raddr <= 1'b1;
            cls_cnt          <= '0;
            restart_pend     <= 1'b0;
          end else if (i_enable && !full[fill_bank]) begin
            state     <= ST_REQ;
            fifo.o_rd <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // later assignments win over the playback updates above
          full       <= 2'b00;
          fill_bank  <= 1'b0;
          play_bank  <= 1'b0;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          o_overflow <= 1'b0;
          if (cls_cnt == CLS_LAST) begin
            fifo.o_cls_raddr <= 1'b0;
            state            <= ST_IDLE;
          end else begin
            cls_cnt <= cls_cnt + CLS_ONE;
          end
        end
        ST_REQ, ST_COLLECT: begin
          if (wr_en)
            wr_ptr <= wr_cnt;
          if (fifo.i_rd_ef && !wr_room)
            o_overflow <= 1'b1;
          if (fifo.i_rd_ef && state == ST_REQ)
            state <= ST_COLLECT;
          if (fifo.i_rd_done) begin
            fifo.o_rd <= 1'b0;
            wr_ptr    <= '0;
            state     <= ST_IDLE;
            if (fill_done)
              fill_bank <= ~fill_bank;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wave_reader.sv
// Directed bench for sdram_wave_reader: fill, playback, underrun,
// overflow, restart, continuous streaming and mid-operation reset.
module tb_sdram_wave_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        restart;
  logic        tick;
  logic [15:0] sample;
  logic        sample_vld;
  logic        underrun;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sdram_wave_reader_if #(.DATA_WIDTH(16)) fif ();

  sdram_wave_reader #(
    .WAVE_SIZE (32),
    .DATA_WIDTH(16),
    .PTR_WIDTH (5),
    .CLS_CYCLES(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_restart    (restart),
    .fifo         (fif),
    .i_sample_tick(tick),
    .o_sample     (sample),
    .o_sample_vld (sample_vld),
    .o_underrun   (underrun),
    .o_overflow   (overflow),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_rd;
    int t = 0;
    while (fif.o_rd !== 1'b1 && t < 3000) begin
      step();
      t++;
    end
    checks++;
    if (fif.o_rd !== 1'b1) begin
      errors++;
      $display("FAIL rd_wait got=%b exp=1", fif.o_rd);
    end
  endtask

  task automatic feed_word(input logic [15:0] d, input bit last_done);
    fif.i_rd_data = d;
    fif.i_rd_ef   = 1'b1;
    fif.i_rd_done = last_done;
    step();
    fif.i_rd_ef   = 1'b0;
    fif.i_rd_done = 1'b0;
  endtask

  task automatic pulse_done;
    fif.i_rd_done = 1'b1;
    step();
    fif.i_rd_done = 1'b0;
  endtask

  task automatic serve_wave(input int n, input logic [15:0] base,
                            input int gap, input bit coinc);
    wait_rd();
    for (int i = 0; i < n; i++) begin
      feed_word(base + 16'(i), coinc && (i == n - 1));
      repeat (gap) step();
    end
    if (!coinc)
      pulse_done();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({fif.o_rd, fif.o_cls_raddr, sample, sample_vld,
         underrun, overflow, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outs got=%b/%b/%h/%b/%b/%b/%b exp=all0",
               fif.o_rd, fif.o_cls_raddr, sample, sample_vld,
               underrun, overflow, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || fif.o_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got=busy%b rd%b exp=0/0", busy, fif.o_rd);
    end
  endtask

  task automatic test_underrun;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++;
      if (underrun !== 1'b1 || sample_vld !== 1'b0 || sample !== 16'h0) begin
        errors++;
        $display("FAIL underrun_%0d got=u%b v%b s%h exp=u1 v0 s0000",
                 i, underrun, sample_vld, sample);
      end
    end
    step();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pulse got=%b exp=0", underrun);
    end
  endtask

  task automatic play_check(input string nm, input logic [15:0] base);
    for (int i = 0; i < 32; i++) begin
      pulse_tick();
      checks++;
      if (sample_vld !== 1'b1 || sample !== base + 16'(i)) begin
        errors++;
        $display("FAIL %s_%0d got=v%b s%h exp=v1 s%h",
                 nm, i, sample_vld, sample, base + 16'(i));
      end
    end
  endtask

  task automatic test_fill_play;
    enable = 1'b1;
    serve_wave(32, 16'h0100, 0, 1'b0);
    checks++;
    if (fif.o_rd !== 1'b0 || dut.full !== 2'b01 || dut.fill_bank !== 1'b1) begin
      errors++;
      $display("FAIL fill_done got=rd%b full%b fb%b exp=rd0 full01 fb1",
               fif.o_rd, dut.full, dut.fill_bank);
    end
    step();
    checks++;
    if (fif.o_rd !== 1'b1) begin
      errors++;
      $display("FAIL second_req got=%b exp=1", fif.o_rd);
    end
    play_check("play0", 16'h0100);
    checks++;
    if (dut.full !== 2'b00 || dut.play_bank !== 1'b1) begin
      errors++;
      $display("FAIL play_swap got=full%b pb%b exp=full00 pb1",
               dut.full, dut.play_bank);
    end
  endtask

  task automatic test_overflow;
    serve_wave(33, 16'h0200, 0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || dut.full !== 2'b10) begin
      errors++;
      $display("FAIL overflow got=ov%b full%b exp=ov1 full10",
               overflow, dut.full);
    end
    play_check("play1", 16'h0200);
    pulse_tick();
    checks++;
    if (underrun !== 1'b1 || sample !== 16'h021F) begin
      errors++;
      $display("FAIL hold got=u%b s%h exp=u1 s021f", underrun, sample);
    end
  endtask

  task automatic test_restart;
    wait_rd();
    for (int i = 0; i < 5; i++)
      feed_word(16'h0300 + 16'(i), 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (fif.o_rd !== 1'b1 || fif.o_cls_raddr !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL restart_hold got=rd%b cls%b ov%b exp=rd1 cls0 ov1",
               fif.o_rd, fif.o_cls_raddr, overflow);
    end
    for (int i = 5; i < 32; i++)
      feed_word(16'h0300 + 16'(i), 1'b0);
    pulse_done();
    checks++;
    if (fif.o_rd !== 1'b0 || fif.o_cls_raddr !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got=rd%b cls%b exp=0/0",
               fif.o_rd, fif.o_cls_raddr);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fif.o_cls_raddr !== 1'b1 || fif.o_rd !== 1'b0) begin
        errors++;
        $display("FAIL cls_%0d got=cls%b rd%b exp=cls1 rd0",
                 i, fif.o_cls_raddr, fif.o_rd);
      end
    end
    step();
    checks++;
    if (fif.o_cls_raddr !== 1'b0 || dut.full !== 2'b00 ||
        overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cls_end got=cls%b full%b ov%b busy%b exp=0/00/0/0",
               fif.o_cls_raddr, dut.full, overflow, busy);
    end
  endtask

  task automatic test_continuous;
    int unders = 0;
    serve_wave(32, 16'h3000, 1, 1'b0);
    fork
      begin
        for (int w = 1; w < 10; w++)
          serve_wave(32, 16'h3000 + 16'(w * 256), 1, w[0]);
      end
      begin
        for (int w = 0; w < 10; w++) begin
          checks++;
          if (dut.play_bank !== w[0]) begin
            errors++;
            $display("FAIL bank_order_%0d got=%b exp=%b",
                     w, dut.play_bank, w[0]);
          end
          for (int i = 0; i < 32; i++) begin
            logic [15:0] exp_s;
            exp_s = 16'h3000 + 16'(w * 256 + i);
            pulse_tick();
            if (underrun === 1'b1)
              unders++;
            checks++;
            if (sample_vld !== 1'b1 || sample !== exp_s) begin
              errors++;
              $display("FAIL stream_w%0d_%0d got=v%b s%h exp=v1 s%h",
                       w, i, sample_vld, sample, exp_s);
            end
            repeat (19) step();
          end
        end
      end
    join
    checks++;
    if (unders !== 0) begin
      errors++;
      $display("FAIL stream_underruns got=%0d exp=0", unders);
    end
  endtask

  task automatic test_reset_mid;
    serve_wave(32, 16'h5000, 0, 1'b0);
    wait_rd();
    for (int i = 0; i < 5; i++)
      feed_word(16'h5100 + 16'(i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      checks++;
      if (sample_vld !== 1'b1 || sample !== 16'h5000 + 16'(i)) begin
        errors++;
        $display("FAIL mid_play_%0d got=v%b s%h exp=v1 s%h",
                 i, sample_vld, sample, 16'h5000 + 16'(i));
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({fif.o_rd, fif.o_cls_raddr, sample, sample_vld,
         underrun, overflow, busy} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset got=%b/%b/%h/%b/%b/%b/%b exp=all0",
               fif.o_rd, fif.o_cls_raddr, sample, sample_vld,
               underrun, overflow, busy);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (fif.o_rd !== 1'b1 || busy !== 1'b1 || dut.full !== 2'b00) begin
      errors++;
      $display("FAIL post_reset got=rd%b busy%b full%b exp=rd1 busy1 full00",
               fif.o_rd, busy, dut.full);
    end
    serve_wave(32, 16'h6000, 0, 1'b0);
    pulse_tick();
    checks++;
    if (sample_vld !== 1'b1 || sample !== 16'h6000) begin
      errors++;
      $display("FAIL post_reset_play got=v%b s%h exp=v1 s6000",
               sample_vld, sample);
    end
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    restart       = 1'b0;
    tick          = 1'b0;
    fif.i_rd_data = '0;
    fif.i_rd_ef   = 1'b0;
    fif.i_rd_done = 1'b0;
    test_reset();
    test_underrun();
    test_fill_play();
    test_overflow();
    test_restart();
    test_continuous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
